// File: rtl/nco_mod_cnt_if.sv
// Port bundle for nco_mod_cnt: divider/counter controls from the master,
// counter value and pulses back from the slave.
interface nco_mod_cnt_if #(
  parameter int NCO_W = 32,
  parameter int CNT_W = 6
);
  logic [NCO_W-1:0] num;
  logic             en;
  logic             src_sel;
  logic             tick_in;
  logic             up;
  logic [CNT_W-1:0] max;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] out;
  logic             tick;
  logic             carry;

  modport master (
    output num, en, src_sel, tick_in, up, max, load, load_val,
    input  out, tick, carry
  );

  modport slave (
    input  num, en, src_sel, tick_in, up, max, load, load_val,
    output out, tick, carry
  );
endinterface

// File: rtl/nco_mod_cnt.sv
// Modulo 0..max up/down counter stepped by an internal NCO tick divider or an
// external strobe; carry pulses on wrap/borrow so stages can be cascaded.
module nco_mod_cnt #(
  parameter int NCO_W = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  nco_mod_cnt_if.slave    bus
);

  localparam logic [NCO_W-1:0] ACC_ONE = NCO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NCO_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             tick_q, tick_d;
  logic             carry_q, carry_d;

  logic [NCO_W-1:0] term_cnt;
  logic             term;
  logic             step;

  // num of 0 behaves like 1; >= lets a lowered num terminate immediately
  assign term_cnt = (bus.num == '0) ? '0 : (bus.num - ACC_ONE);
  assign term     = (acc_q >= term_cnt);
  assign step     = bus.src_sel ? bus.tick_in : tick_q;

  always_comb begin
    acc_d   = acc_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (bus.load) begin
      out_d = bus.load_val;
      acc_d = '0;
    end else if (bus.en) begin
      if (term) begin
        acc_d  = '0;
        tick_d = 1'b1;
      end else begin
        acc_d  = acc_q + ACC_ONE;
      end
      // compare before stepping so max = all-ones never overflows
      if (step) begin
        if (bus.up) begin
          if (out_q >= bus.max) begin
            out_d   = '0;
            carry_d = 1'b1;
          end else begin
            out_d   = out_q + CNT_ONE;
          end
        end else begin
          if (out_q == '0) begin
            out_d   = bus.max;
            carry_d = 1'b1;
          end else if (out_q > bus.max) begin
            out_d   = bus.max;
          end else begin
            out_d   = out_q - CNT_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      out_q   <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.tick  = tick_q;
  assign bus.carry = carry_q;

endmodule
